// File: rtl/pingpong_buffer.sv
// pingpong_buffer: two-bank frame sink. The producer fills one bank while the
// consumer drains the other under valid/ready; banks alternate 0, 1, 0, ...
module pingpong_buffer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 240
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              overflow,
    output logic [1:0]        bank_full
);

    localparam int unsigned   CNT_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    // Storage: two banks, written one word per cycle, read combinationally
    logic [DATA_W-1:0] mem_q [2][DEPTH];

    // Write-side state
    logic              wr_bank_q;
    logic [CNT_W-1:0]  wr_cnt_q;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              overflow_q;

    // Read-side state
    rd_state_e         state_q;
    logic              rd_bank_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic              out_last_q;

    // Combinational helpers
    logic              accept_c;
    logic              release_c;
    logic              writable_c;
    logic              wr_fire_c;
    logic              wr_drop_c;
    logic              wr_wrap_c;
    logic              rd_other_c;
    logic [CNT_W-1:0]  rd_nxt_idx_c;
    logic [DATA_W-1:0] rd_nxt_word_c;
    logic [DATA_W-1:0] rd_cur_first_c;
    logic [DATA_W-1:0] rd_oth_first_c;

    assign accept_c   = out_valid_q && out_ready;
    // The reader gives its bank back on the accept of the last word
    assign release_c  = (state_q == STREAM) && accept_c && (rd_cnt_q == LAST_IDX);
    // A full bank is still writable on the very edge it is being released
    assign writable_c = !full_q[wr_bank_q] || (release_c && (rd_bank_q == wr_bank_q));
    assign wr_fire_c  = in_en && writable_c;
    assign wr_drop_c  = in_en && !writable_c;
    assign wr_wrap_c  = wr_fire_c && (wr_cnt_q == LAST_IDX);

    assign rd_other_c     = ~rd_bank_q;
    assign rd_nxt_idx_c   = (rd_cnt_q == LAST_IDX) ? '0 : (rd_cnt_q + CNT_W'(1));
    assign rd_nxt_word_c  = mem_q[rd_bank_q][rd_nxt_idx_c];
    assign rd_cur_first_c = mem_q[rd_bank_q][0];
    assign rd_oth_first_c = mem_q[rd_other_c][0];

    // Full flags: release clears the read bank, completing a bank sets it
    always_comb begin
        full_d = full_q;
        if (release_c) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (wr_wrap_c) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Bank memory write port (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            mem_q[wr_bank_q][wr_cnt_q] <= in_data;
        end
    end

    // Write pointer, full flags and overflow pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            full_q     <= 2'b00;
            overflow_q <= 1'b0;
        end else begin
            full_q     <= full_d;
            overflow_q <= wr_drop_c;
            if (wr_fire_c) begin
                if (wr_cnt_q == LAST_IDX) begin
                    wr_cnt_q  <= '0;
                    wr_bank_q <= ~wr_bank_q;
                end else begin
                    wr_cnt_q  <= wr_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Read FSM: presents one registered word at a time, chains banks without a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        out_data_q  <= rd_cur_first_c;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        rd_cnt_q    <= '0;
                        state_q     <= STREAM;
                    end else begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                    end
                end
                STREAM: begin
                    if (accept_c) begin
                        if (rd_cnt_q != LAST_IDX) begin
                            rd_cnt_q   <= rd_nxt_idx_c;
                            out_data_q <= rd_nxt_word_c;
                            out_last_q <= (rd_nxt_idx_c == LAST_IDX);
                        end else begin
                            rd_bank_q <= rd_other_c;
                            if (full_q[rd_other_c]) begin
                                out_data_q <= rd_oth_first_c;
                                rd_cnt_q   <= '0;
                                out_last_q <= 1'b0;
                            end else begin
                                out_valid_q <= 1'b0;
                                out_last_q  <= 1'b0;
                                state_q     <= IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    out_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign overflow  = overflow_q;
    assign bank_full = full_q;

endmodule
